// File: rtl/byte_masked_reg_file.sv
// ---------------------------------------------------------------------------
// byte_masked_reg_file
//
// Byte-masked register file used for control/data staging in the datapath.
// Holds DEPTH words of DATA_W bits. Writes arrive over a valid/ready
// handshake with a per-byte lane enable. Reads are registered with a
// one-cycle latency and are read-first against a same-cycle write. A clr
// pulse starts a background sweep that zeroes one entry per cycle. Writes
// are held off while the sweep runs, but reads are still served.
//
// Optional feature macro: BYTE_MASKED_REG_FILE_PARITY_EN
//   When defined, one even-parity bit is stored per byte lane and is checked
//   on the read path. inj_perr corrupts the stored parity of written lanes.
//   When undefined, rd_perr is tied to 0 and inj_perr is ignored.
//
// Parameters:
//   DATA_W    word width in bits (multiple of 8), NB = DATA_W/8 lanes
//   DEPTH     number of entries (>= 2), AW = $clog2(DEPTH)
//   CLR_UNSEL 0: lanes not enabled keep their value, 1: they are zeroed
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   wr_valid/wr_ready    write handshake; wr_ready is low only during a sweep
//   wr_addr/wr_byteena/wr_data  write entry, lane enables, data
//   inj_perr             flip stored parity of enabled lanes (test input)
//   clr                  single-cycle pulse, starts the clear sweep
//   rd_req/rd_addr       read request and entry index
//   rd_valid/rd_data     one-cycle valid pulse with registered read data
//   rd_perr              per-lane parity error, qualified by rd_valid
// ---------------------------------------------------------------------------
module byte_masked_reg_file #(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 8,
  parameter  int CLR_UNSEL = 0,
  localparam int NB        = DATA_W / 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [NB-1:0]     wr_byteena,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              inj_perr,
  output logic [NB-1:0]     rd_perr
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Even parity of one byte lane: the stored bit makes the 9-bit group even.
  function automatic logic lane_parity(input logic [7:0] lane);
    return ^lane;
  endfunction

  // Addresses at or above DEPTH are legal on the bus but map to no entry.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({{(32-AW){1'b0}}, addr} < $unsigned(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [AW-1:0]     ptr_r;
  logic [AW-1:0]     ptr_nxt_s;
  logic              wr_fire_s;

  assign wr_ready  = (state_r == ST_IDLE);
  assign wr_fire_s = wr_valid && wr_ready;

  // Sweep controller next-state: a clr seen during the sweep is ignored.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (clr) begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = ptr_r;
        end
      end
      ST_CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = ST_IDLE;
          ptr_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_CLEAR;
          ptr_nxt_s   = ptr_r + AW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = '0;
      end
    endcase
  end

  // Sweep controller state and pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Data storage: sweep clear has priority; writes cannot fire while sweeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[ptr_r] <= '0;
    end else if (wr_fire_s && in_range(wr_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_byteena[b]) begin
          mem_r[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end else if (CLR_UNSEL != 0) begin
          mem_r[wr_addr][8*b +: 8] <= 8'h00;
        end
      end
    end
  end

  // Registered read port: samples the pre-write contents (read-first).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= in_range(rd_addr) ? mem_r[rd_addr] : '0;
      end
    end
  end

`ifdef BYTE_MASKED_REG_FILE_PARITY_EN
  logic [NB-1:0] par_r [DEPTH];

  // Parity storage tracks the data storage lane by lane; inj_perr inverts
  // the bit of every lane written in that transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_r[i] <= '0;
      end
    end else if (state_r == ST_CLEAR) begin
      par_r[ptr_r] <= '0;
    end else if (wr_fire_s && in_range(wr_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_byteena[b]) begin
          par_r[wr_addr][b] <= lane_parity(wr_data[8*b +: 8]) ^ inj_perr;
        end else if (CLR_UNSEL != 0) begin
          par_r[wr_addr][b] <= 1'b0;
        end
      end
    end
  end

  // Parity check registered alongside rd_data; unmapped addresses read clean.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_perr <= '0;
    end else if (rd_req) begin
      if (in_range(rd_addr)) begin
        for (int b = 0; b < NB; b++) begin
          rd_perr[b] <= par_r[rd_addr][b] ^ lane_parity(mem_r[rd_addr][8*b +: 8]);
        end
      end else begin
        rd_perr <= '0;
      end
    end
  end
`else
  logic unused_inj_s;

  assign unused_inj_s = inj_perr;
  assign rd_perr      = '0;
`endif

endmodule

// File: tb/tb_byte_masked_reg_file.sv
// ---------------------------------------------------------------------------
// tb_byte_masked_reg_file
//
// Drives two instances with shared stimulus: u_keep (DEPTH=8, CLR_UNSEL=0)
// and u_zero (DEPTH=6, CLR_UNSEL=1, so addresses 6 and 7 are unmapped).
// A reference model keeps each instance's contents as plain word arrays and
// derives sweep timing from the edge number at which clr was accepted.
// ---------------------------------------------------------------------------
module tb_byte_masked_reg_file;

`ifdef BYTE_MASKED_REG_FILE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_byteena;
  logic [31:0] wr_data;
  logic        clr;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic        inj_perr;

  logic [1:0]  wr_ready_w;
  logic [1:0]  rd_valid_w;
  logic [31:0] rd_data_w [2];
  logic [3:0]  rd_perr_w [2];

  byte_masked_reg_file #(.DATA_W(32), .DEPTH(8), .CLR_UNSEL(0)) u_keep (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready_w[0]),
    .wr_addr(wr_addr), .wr_byteena(wr_byteena), .wr_data(wr_data), .clr(clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_w[0]),
    .rd_data(rd_data_w[0]), .inj_perr(inj_perr), .rd_perr(rd_perr_w[0])
  );

  byte_masked_reg_file #(.DATA_W(32), .DEPTH(6), .CLR_UNSEL(1)) u_zero (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready_w[1]),
    .wr_addr(wr_addr), .wr_byteena(wr_byteena), .wr_data(wr_data), .clr(clr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid_w[1]),
    .rd_data(rd_data_w[1]), .inj_perr(inj_perr), .rd_perr(rd_perr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int          n_assert = 0;
  int          n_fail   = 0;
  int          ecount   = 0;
  int          dep   [2] = '{8, 6};
  int          unsel [2] = '{0, 1};
  int          clr_edge [2] = '{-1000000, -1000000};
  logic [31:0] mdl   [2][8];
  logic [3:0]  mperr [2][8];
  logic [31:0] last_d [2];
  logic [3:0]  last_p [2];
  logic [31:0] fill [8];
  int          low_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit sweeping(input int i, input int ed);
    return (ed > clr_edge[i]) && (ed <= clr_edge[i] + dep[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 8; a++) begin
        mdl[i][a]   = 32'h0;
        mperr[i][a] = 4'h0;
      end
      clr_edge[i] = -1000000;
      last_d[i]   = 32'h0;
      last_p[i]   = 4'h0;
    end
  endtask

  task automatic quiet();
    wr_valid = 1'b0; wr_addr = 3'd0; wr_byteena = 4'h0; wr_data = 32'h0;
    clr = 1'b0; rd_req = 1'b0; rd_addr = 3'd0; inj_perr = 1'b0;
  endtask

  // One clock: predict from the current inputs, advance, then compare.
  task automatic tick();
    logic [31:0] w;
    logic [3:0]  p;
    bit          sw;
    for (int i = 0; i < 2; i++) begin
      sw = sweeping(i, ecount);
      chk($sformatf("wr_ready[%0d]", i), {31'h0, wr_ready_w[i]}, {31'h0, !sw});
      if (rd_req) begin
        if (int'(rd_addr) < dep[i]) begin
          last_d[i] = mdl[i][rd_addr];
          last_p[i] = PAR ? mperr[i][rd_addr] : 4'h0;
        end else begin
          last_d[i] = 32'h0;
          last_p[i] = 4'h0;
        end
      end
      if (wr_valid && !sw && int'(wr_addr) < dep[i]) begin
        w = mdl[i][wr_addr];
        p = mperr[i][wr_addr];
        for (int b = 0; b < 4; b++) begin
          if (wr_byteena[b]) begin
            w[8*b +: 8] = wr_data[8*b +: 8];
            p[b]        = inj_perr;
          end else if (unsel[i] != 0) begin
            w[8*b +: 8] = 8'h00;
            p[b]        = 1'b0;
          end
        end
        mdl[i][wr_addr]   = w;
        mperr[i][wr_addr] = p;
      end
      if (sw) begin
        mdl[i][ecount - clr_edge[i] - 1]   = 32'h0;
        mperr[i][ecount - clr_edge[i] - 1] = 4'h0;
      end
      if (clr && !sw) clr_edge[i] = ecount;
    end
    @(posedge clk);
    #1;
    ecount++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_valid[%0d]", i), {31'h0, rd_valid_w[i]}, {31'h0, rd_req});
      chk($sformatf("rd_data[%0d]", i), rd_data_w[i], last_d[i]);
      chk($sformatf("rd_perr[%0d]", i), {28'h0, rd_perr_w[i]}, {28'h0, last_p[i]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_wr_ready[%0d]", tag, i), {31'h0, wr_ready_w[i]}, 32'h1);
      chk($sformatf("%s_rd_valid[%0d]", tag, i), {31'h0, rd_valid_w[i]}, 32'h0);
      chk($sformatf("%s_rd_data[%0d]", tag, i), rd_data_w[i], 32'h0);
      chk($sformatf("%s_rd_perr[%0d]", tag, i), {28'h0, rd_perr_w[i]}, 32'h0);
    end
  endtask

  initial begin
    quiet();
    model_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Reset contents: every address reads 0, valid one cycle after request.
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = 3'(a);
      tick();
      chk("reset_read", rd_data_w[0], 32'h0);
    end
    quiet();
    tick();

    // Masked write sequence on entry 2.
    wr_valid = 1'b1; wr_addr = 3'd2; wr_byteena = 4'b1111; wr_data = 32'hAABBCCDD;
    tick();
    wr_byteena = 4'b0101; wr_data = 32'h11223344;
    tick();
    quiet();
    rd_req = 1'b1; rd_addr = 3'd2;
    tick();
    chk("mask_keep", rd_data_w[0], 32'hAA22CC44);
    chk("mask_zero", rd_data_w[1], 32'h00220044);

    // Read-first: same-cycle write and read of entry 3.
    quiet();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_byteena = 4'hF; wr_data = 32'h12345678;
    rd_req = 1'b1; rd_addr = 3'd3;
    tick();
    chk("read_first_old", rd_data_w[0], 32'h0);
    quiet();
    rd_req = 1'b1; rd_addr = 3'd3;
    tick();
    chk("read_first_new", rd_data_w[0], 32'h12345678);

    // Empty byte enable: keep policy is a no-op, zero policy clears entry.
    quiet();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_byteena = 4'h0; wr_data = 32'hFFFFFFFF;
    tick();
    quiet();
    rd_req = 1'b1; rd_addr = 3'd3;
    tick();
    chk("be0_keep", rd_data_w[0], 32'h12345678);
    chk("be0_zero", rd_data_w[1], 32'h0);

    // Parity injection, then a clean rewrite.
    quiet();
    wr_valid = 1'b1; wr_addr = 3'd4; wr_byteena = 4'b0011; wr_data = 32'hFF00FF00; inj_perr = 1'b1;
    tick();
    quiet();
    rd_req = 1'b1; rd_addr = 3'd4;
    tick();
    chk("perr_inj", {28'h0, rd_perr_w[0]}, PAR ? 32'h3 : 32'h0);
    quiet();
    wr_valid = 1'b1; wr_addr = 3'd4; wr_byteena = 4'b0011; wr_data = 32'hFF00FF00;
    tick();
    quiet();
    rd_req = 1'b1; rd_addr = 3'd4;
    tick();
    chk("perr_clean", {28'h0, rd_perr_w[0]}, 32'h0);

    // Randomized traffic including unmapped addresses and occasional clr.
    for (int n = 0; n < 400; n++) begin
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = 3'($urandom_range(0, 7));
      wr_byteena = 4'($urandom_range(0, 15));
      wr_data    = $urandom;
      inj_perr   = ($urandom_range(0, 3) == 0);
      rd_req     = 1'($urandom_range(0, 1));
      rd_addr    = 3'($urandom_range(0, 7));
      clr        = ($urandom_range(0, 39) == 0);
      tick();
    end
    quiet();
    repeat (10) tick();

    // Fill all entries, then sweep while a write is held pending.
    for (int a = 0; a < 8; a++) begin
      fill[a] = 32'hA5A50000 | 32'(a + 1);
      wr_valid = 1'b1; wr_addr = 3'(a); wr_byteena = 4'hF; wr_data = fill[a];
      tick();
    end
    quiet();
    low_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      wr_valid = (t < 9); wr_addr = 3'd1; wr_byteena = 4'hF; wr_data = 32'hDEAD0000 | 32'(t);
      clr      = (t == 0) || (t == 4);
      rd_req   = (t == 3); rd_addr = 3'd5;
      if (wr_ready_w[0] == 1'b0) low_cnt++;
      tick();
      if (t == 3) chk("sweep_read_old", rd_data_w[0], fill[5]);
    end
    chk("sweep_len", 32'(low_cnt), 32'd8);
    quiet();
    for (int a = 0; a < 8; a++) begin
      rd_req = 1'b1; rd_addr = 3'(a);
      tick();
      chk("sweep_after", rd_data_w[0], 32'h0);
    end

    // Reset during a sweep takes effect immediately.
    quiet();
    wr_valid = 1'b1; wr_addr = 3'd6; wr_byteena = 4'hF; wr_data = 32'h0BADF00D;
    tick();
    quiet();
    clr = 1'b1;
    tick();
    quiet();
    repeat (2) tick();
    resetn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midsweep_reset");
    #2;
    resetn = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd6; wr_byteena = 4'hF; wr_data = 32'hCAFE0006;
    tick();
    quiet();
    rd_req = 1'b1; rd_addr = 3'd6;
    tick();
    chk("post_reset_write", rd_data_w[0], 32'hCAFE0006);
    rd_addr = 3'd2;
    tick();
    chk("post_reset_clear", rd_data_w[0], 32'h0);
    quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_masked_reg_file.md
# byte_masked_reg_file

Parametrised, byte-masked register file for control/data staging in the datapath. Holds DEPTH words of DATA_W bits, accepts per-byte masked writes over a valid/ready handshake, serves registered reads with 1-cycle latency, and supports a background bank clear that sweeps one entry per cycle. Optional per-byte parity adds storage error detection on the read path.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- DEPTH, 8, number of entries (≥2). AW = $clog2(DEPTH).
- CLR_UNSEL, 0, unselected-lane policy: 0 = unselected bytes keep their value; 1 = unselected bytes are written 0.

- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted; 0 only during a clear sweep.
- wr_addr  in  AW  write entry index.
- wr_byteena  in  NB  lane enable; bit i covers wr_data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- clr  in  1  single-cycle pulse; starts the bank clear sweep.
- rd_req  in  1  read request.
- rd_addr  in  AW  read entry index.
- rd_valid  out  1  rd_data valid; one-cycle pulse per request.
- rd_data  out  DATA_W  read data.
- inj_perr  in  1  test input; when set on an accepted write, flips the stored parity of every enabled lane. Ignored unless parity is compiled in.
- rd_perr  out  NB  per-lane parity error, qualified by rd_valid. Tied 0 unless parity is compiled in.

## Operation
- Write is accepted when wr_valid && wr_ready are both high at a rising edge. Each lane i is loaded from wr_data when wr_byteena[i]=1. Otherwise it holds its value (CLR_UNSEL=0) or is set to 0 (CLR_UNSEL=1).
  - wr_byteena=0 with CLR_UNSEL=1 zeroes the whole entry.
  - wr_byteena=0 with CLR_UNSEL=0 is a no-op that still completes the handshake.
- wr_addr ≥ DEPTH: write is accepted and discarded. rd_addr ≥ DEPTH: the read returns rd_data=0 with rd_valid=1.
- FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR when clr=1; the pointer is set to 0.
  - In CLEAR, entry[ptr] is set to 0 (parity 0) each cycle and ptr increments. CLEAR→IDLE on the cycle ptr==DEPTH-1 is cleared.
  - clr asserted while in CLEAR is ignored and does not restart the sweep.
- wr_ready = (state==IDLE), decoded combinationally from the state register.
- Reads are serviced in both states. During CLEAR, reads return the partially cleared contents.
- Same-cycle read and write to the same address: the read returns the pre-write contents (read-first).
- clr and an accepted write in the same IDLE cycle: the write lands, and the sweep clears it later.
- Reset mid-sweep: all entries become 0, state goes to IDLE, and the pointer goes to 0 immediately.

## Timing
- Reset values: every entry 0, parity bits 0, rd_data 0, rd_valid 0, rd_perr 0, state IDLE, wr_ready 1.
- Write: data is visible to a read requested on the cycle after acceptance.
- Read latency is 1 cycle. A request sampled at edge N gives rd_valid=1 and rd_data after edge N, for one cycle. Back-to-back requests give back-to-back data.
- rd_data holds its last value while rd_valid=0.
- Clear: with clr sampled at edge N, wr_ready=0 from after edge N until after edge N+DEPTH. Entry k is 0 after edge N+1+k.

## Configuration
- BYTE_MASKED_REG_FILE_PARITY_EN defined:
  - One even-parity bit per lane is stored on write (lane written) or clear (0). Retained lanes keep their bit; lanes zeroed by CLR_UNSEL get parity 0.
  - On read, rd_perr[i] = stored parity ^ ^rd_data_lane_i, registered alongside rd_data.
  - inj_perr corrupts the stored parity as described above.
- Not defined: no parity storage, rd_perr constant 0, inj_perr unused.

## Test plan
- Reset then read all addresses -> rd_valid one cycle after each request, rd_data=0, wr_ready=1.
- DATA_W=32, CLR_UNSEL=0: write 0xAABBCCDD at addr 2 with byteena 4'b1111, then 0x11223344 with 4'b0101 -> read addr 2 returns 0xAA22CC44. Same sequence with CLR_UNSEL=1 -> 0x00220044.
- Same-cycle write 0x12345678 and read of addr 3 (old 0) -> rd_data=0. Next-cycle read -> 0x12345678.
- Fill DEPTH=8 with nonzero data, pulse clr, hold wr_valid=1 -> wr_ready low for exactly 8 cycles, no write lands. A read of entry 5 at sweep cycle 3 returns old data; after the sweep all reads return 0. A second clr pulse mid-sweep does not extend the sweep.
- Assert resetn low at sweep cycle 2 -> all entries 0 and wr_ready=1 immediately. A write right after reset is accepted.
- PARITY_EN: write 0xFF00FF00 with inj_perr=1 and byteena 4'b0011 -> read gives rd_perr=4'b0011. Rewriting without inj_perr -> rd_perr=0. Without the macro -> rd_perr always 0.
